rdma_rd_mux_credit: RTL and testbench

RDMA_RD_MUX_CREDIT -- requirements
Module: rdma_rd_mux_credit

---
 rtl/rdma_rd_mux_credit_pkg.sv | 23 ++
 rtl/rdma_rd_seq_fifo.sv | 50 +++++
 rtl/rdma_rd_mux_credit.sv | 178 +++++++++++++++++
 tb/tb_rdma_rd_mux_credit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdma_rd_mux_credit_pkg.sv
// Shared types and sizing helpers for the RDMA read-stream mux and its sequence queue.
package rdma_rd_mux_credit_pkg;

  // Queue entries are sized for the widest legal configuration (16 channels, 32-bit length).
  localparam int SEQ_VFID_W = 4;
  localparam int SEQ_LEN_W  = 32;

  typedef struct packed {
    logic [SEQ_VFID_W-1:0] vfid;
    logic [SEQ_LEN_W-1:0]  len;
  } rd_seq_t;

  typedef enum logic {ST_IDLE, ST_MUX} mux_state_e;

  function automatic int beat_log(input int data_bits);
    return $clog2(data_bits / 8);
  endfunction

  function automatic int ch_bits(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/rdma_rd_seq_fifo.sv
// Synchronous FIFO of read-sequence entries; head entry is visible whenever not empty.
module rdma_rd_seq_fifo
  import rdma_rd_mux_credit_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           aclk,
  input  logic           areset,
  input  logic           push,
  input  rd_seq_t        din,
  input  logic           pop,
  output rd_seq_t        dout,
  output logic           empty,
  output logic           full,
  output logic [PTR_W:0] used
);

  rd_seq_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty   = (used == '0);
  assign full    = (used == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full queue lands only when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   used <= used + (PTR_W+1)'(1);
        2'b01:   used <= used - (PTR_W+1)'(1);
        default: used <= used;
      endcase
    end
  end

endmodule

// File: rtl/rdma_rd_mux_credit.sv
// Forwards read commands per channel and replays their data streams in command order
// onto one AXI-Stream, counting beats from the command length.
module rdma_rd_mux_credit
  import rdma_rd_mux_credit_pkg::*;
#(
  parameter  int N_CH      = 4,
  parameter  int DATA_BITS = 512,
  parameter  int LEN_BITS  = 28,
  parameter  int SEQ_DEPTH = 16,
  parameter  int TLAST_GEN = 1,
  localparam int CH_BITS   = ch_bits(N_CH),
  localparam int BEAT_LOG  = beat_log(DATA_BITS),
  localparam int KEEP_BITS = DATA_BITS / 8,
  localparam int USED_BITS = $clog2(SEQ_DEPTH) + 1
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic                             s_req_valid,
  output logic                             s_req_ready,
  input  logic [CH_BITS:0]                 s_req_vfid,
  input  logic [LEN_BITS-1:0]              s_req_len,
  input  logic                             s_req_host,
  output logic [N_CH-1:0]                  m_req_valid,
  input  logic [N_CH-1:0]                  m_req_ready,
  output logic [LEN_BITS-1:0]              m_req_len,
  input  logic [N_CH-1:0]                  s_axis_tvalid,
  output logic [N_CH-1:0]                  s_axis_tready,
  input  logic [N_CH-1:0]                  s_axis_tlast,
  input  logic [N_CH-1:0][DATA_BITS-1:0]   s_axis_tdata,
  input  logic [N_CH-1:0][KEEP_BITS-1:0]   s_axis_tkeep,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast,
  output logic [DATA_BITS-1:0]             m_axis_tdata,
  output logic [KEEP_BITS-1:0]             m_axis_tkeep,
  output logic                             err_vfid,
  output logic [USED_BITS-1:0]             seq_used
);

  localparam logic [LEN_BITS:0] BPB_M1  = (LEN_BITS+1)'(KEEP_BITS - 1);
  localparam logic [LEN_BITS:0] CNT_ONE = (LEN_BITS+1)'(1);

  mux_state_e          state;
  logic [CH_BITS-1:0]  vfid_c;
  logic [LEN_BITS:0]   cnt_c;
  logic [BEAT_LOG-1:0] rem_c;

  logic                in_range, ch_ready, can_push, push, pop;
  logic                fifo_empty, fifo_full;
  logic [CH_BITS-1:0]  req_ch;
  rd_seq_t             fifo_din, head;
  logic [LEN_BITS-1:0] head_len;
  logic [CH_BITS-1:0]  head_ch;
  logic [LEN_BITS:0]   head_beats;
  logic                in_mux, beat_hs, final_hs;
  logic                sel_tvalid, sel_tlast;
  logic [DATA_BITS-1:0] sel_tdata;
  logic [KEEP_BITS-1:0] sel_tkeep, last_keep;
  logic                unused_bits;

  // ---------------- command side ----------------
  assign in_range = (s_req_vfid < (CH_BITS+1)'(N_CH));
  assign req_ch   = s_req_vfid[CH_BITS-1:0];
  assign m_req_len = s_req_len;

  always_comb begin
    ch_ready = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (req_ch == CH_BITS'(i)) ch_ready = m_req_ready[i];
  end

  assign can_push = ~fifo_full | pop;

  // Out-of-range commands are always swallowed; host commands need queue room and
  // the target channel at once so forward and push happen together or not at all.
  always_comb begin
    if (!in_range)       s_req_ready = 1'b1;
    else if (s_req_host) s_req_ready = can_push & ch_ready;
    else                 s_req_ready = can_push;
  end

  assign push = s_req_valid & s_req_ready & in_range;

  for (genvar i = 0; i < N_CH; i++) begin : g_mreq
    assign m_req_valid[i] = s_req_valid & in_range & s_req_host & can_push &
                            (req_ch == CH_BITS'(i));
  end

  always_comb begin
    fifo_din      = '0;
    fifo_din.vfid = SEQ_VFID_W'(req_ch);
    fifo_din.len  = SEQ_LEN_W'(s_req_len);
  end

  rdma_rd_seq_fifo #(.DEPTH(SEQ_DEPTH)) u_seq (
    .aclk   (aclk),
    .areset (areset),
    .push   (push),
    .din    (fifo_din),
    .pop    (pop),
    .dout   (head),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .used   (seq_used)
  );

  // ---------------- data side ----------------
  assign head_len   = head.len[LEN_BITS-1:0];
  assign head_ch    = head.vfid[CH_BITS-1:0];
  assign head_beats = ({1'b0, head_len} + BPB_M1) >> BEAT_LOG;

  always_comb begin
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    sel_tdata  = '0;
    sel_tkeep  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (vfid_c == CH_BITS'(i)) begin
        sel_tvalid = s_axis_tvalid[i];
        sel_tlast  = s_axis_tlast[i];
        sel_tdata  = s_axis_tdata[i];
        sel_tkeep  = s_axis_tkeep[i];
      end
    end
  end

  assign in_mux        = (state == ST_MUX);
  assign m_axis_tvalid = in_mux & sel_tvalid;
  assign m_axis_tdata  = sel_tdata;
  assign beat_hs       = m_axis_tvalid & m_axis_tready;
  assign final_hs      = beat_hs & (cnt_c == '0);
  // Popping on the final beat lets the next entry start without an idle cycle.
  assign pop           = ~fifo_empty & (~in_mux | final_hs);

  for (genvar i = 0; i < N_CH; i++) begin : g_srdy
    assign s_axis_tready[i] = in_mux & m_axis_tready & (vfid_c == CH_BITS'(i));
  end

  assign last_keep = (rem_c == '0) ? '1 : ~({KEEP_BITS{1'b1}} << rem_c);

  if (TLAST_GEN != 0) begin : g_tlast_gen
    assign m_axis_tlast = in_mux & (cnt_c == '0);
    assign m_axis_tkeep = (cnt_c == '0) ? last_keep : '1;
  end else begin : g_tlast_pass
    assign m_axis_tlast = sel_tlast;
    assign m_axis_tkeep = sel_tkeep;
  end

  assign unused_bits = ^{head.vfid, head.len, s_axis_tlast, s_axis_tkeep, sel_tlast, sel_tkeep};

  // Zero-length entries are consumed straight from the head without entering ST_MUX.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state    <= ST_IDLE;
      vfid_c   <= '0;
      cnt_c    <= '0;
      rem_c    <= '0;
      err_vfid <= 1'b0;
    end else begin
      err_vfid <= s_req_valid & ~in_range;
      if (pop) begin
        if (head_len != '0) begin
          state  <= ST_MUX;
          vfid_c <= head_ch;
          cnt_c  <= head_beats - CNT_ONE;
          rem_c  <= head_len[BEAT_LOG-1:0];
        end else begin
          state  <= ST_IDLE;
        end
      end else if (final_hs) begin
        state <= ST_IDLE;
      end else if (beat_hs) begin
        cnt_c <= cnt_c - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_rdma_rd_mux_credit.sv
// Directed and randomized checks of the read mux against a command-queue reference model.
module tb_rdma_rd_mux_credit;
  localparam int N_CH = 4, DB = 512, KB = 64, LB = 28, SD = 16;

  logic                     aclk = 1'b0;
  logic                     areset = 1'b1;
  logic                     s_req_valid = 1'b0, s_req_ready, s_req_host = 1'b0;
  logic [2:0]               s_req_vfid = '0;
  logic [LB-1:0]            s_req_len = '0;
  logic [N_CH-1:0]          m_req_valid, m_req_ready = '1;
  logic [LB-1:0]            m_req_len;
  logic [N_CH-1:0]          s_axis_tvalid = '1, s_axis_tready, s_axis_tlast = '0;
  logic [N_CH-1:0][DB-1:0]  s_axis_tdata = '0;
  logic [N_CH-1:0][KB-1:0]  s_axis_tkeep = '1;
  logic                     m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
  logic [DB-1:0]            m_axis_tdata;
  logic [KB-1:0]            m_axis_tkeep;
  logic                     err_vfid;
  logic [4:0]               seq_used;

  always #5 aclk = ~aclk;

  rdma_rd_mux_credit #(.N_CH(N_CH), .DATA_BITS(DB), .LEN_BITS(LB), .SEQ_DEPTH(SD), .TLAST_GEN(1)) dut (
    .aclk(aclk), .areset(areset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_vfid(s_req_vfid),
    .s_req_len(s_req_len), .s_req_host(s_req_host),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_len(m_req_len),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .err_vfid(err_vfid), .seq_used(seq_used)
  );

  typedef struct { int ch; int len; int rem; } cmd_t;
  cmd_t cq[$];
  int   src_cnt[N_CH];
  int   mdl_cnt[N_CH];
  int   checks = 0, errors = 0;
  int   beats = 0, cyc = 0, first_cyc = -1, last_cyc = -1;
  logic [KB-1:0] last_keep_obs = '0;
  logic exp_err = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [DB-1:0] pat(input int ch, input int n);
    logic [7:0]  c8;
    logic [23:0] n24;
    c8  = 8'(ch);
    n24 = 24'(n);
    return {16{c8, n24}};
  endfunction

  task automatic chk(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input int vf, input int len, input logic h);
    s_req_valid = v;
    s_req_vfid  = 3'(vf);
    s_req_len   = LB'(len);
    s_req_host  = h;
  endtask

  task automatic settle();
    for (int c = 0; c < N_CH; c++) begin
      s_axis_tdata[c] = pat(c, src_cnt[c]);
      s_axis_tlast[c] = 1'($urandom_range(0, 1));
    end
    #1;
  endtask

  // Model side: the front command owns the stream until its last byte has been delivered.
  task automatic observe();
    int tch, ech, r;
    logic lst;
    logic [KB-1:0] k;
    cmd_t c;
    cyc++;
    while (cq.size() > 0 && cq[0].len == 0) void'(cq.pop_front());
    chk("err_vfid", err_vfid, exp_err);
    exp_err = !areset && s_req_valid && (s_req_vfid >= N_CH);
    chk("tready_onehot", $countones(s_axis_tready) <= 1, 1);
    if (|s_axis_tready) begin
      tch = -1;
      for (int i = 0; i < N_CH; i++) if (s_axis_tready[i]) tch = i;
      ech = (cq.size() > 0) ? cq[0].ch : -1;
      chk("tready_ch", tch, ech);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (cq.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        c   = cq[0];
        r   = c.rem;
        lst = (r <= KB);
        k   = (lst && r < KB) ? ((64'(1) << r) - 64'(1)) : '1;
        chk("tdata", m_axis_tdata, pat(c.ch, mdl_cnt[c.ch]));
        chk("tlast", m_axis_tlast, lst);
        chk("tkeep", m_axis_tkeep, k);
        mdl_cnt[c.ch]++;
        c.rem = r - KB;
        if (lst) void'(cq.pop_front());
        else cq[0] = c;
      end
      beats++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (m_axis_tlast) last_keep_obs = m_axis_tkeep;
    end
    for (int i = 0; i < N_CH; i++)
      if (s_axis_tvalid[i] && s_axis_tready[i]) src_cnt[i]++;
    if (!areset && s_req_valid && s_req_ready && s_req_vfid < N_CH)
      cq.push_back('{int'(s_req_vfid), int'(s_req_len), int'(s_req_len)});
  endtask

  task automatic advance();
    observe();
    @(negedge aclk);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic clr_stats();
    beats = 0; first_cyc = -1; last_cyc = -1; last_keep_obs = '0;
  endtask

  initial begin
    int s2, s3, u, v, ln, sel;
    logic h;
    logic [N_CH-1:0] exp_mrv;
    for (int i = 0; i < N_CH; i++) begin src_cnt[i] = 0; mdl_cnt[i] = 0; end
    repeat (3) @(negedge aclk);
    areset = 1'b0;

    // reset state
    settle();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_used", seq_used, 0);
    chk("rst_err", err_vfid, 0);
    chk("rst_mreq", m_req_valid, 0);
    advance();

    // host command, 200 bytes on channel 2
    clr_stats(); s2 = src_cnt[2];
    set_req(1, 2, 200, 1); settle();
    chk("a_ready", s_req_ready, 1);
    chk("a_mreq", m_req_valid, 4'b0100);
    advance();
    set_req(0, 0, 0, 0); settle();
    chk("a_mreq_pulse", m_req_valid, 0);
    advance();
    repeat (8) tick();
    chk("a_beats", beats, 4);
    chk("a_src", src_cnt[2] - s2, 4);
    chk("a_lastkeep", last_keep_obs, 64'h00FF);
    chk("a_drained", cq.size(), 0);

    // back-to-back entries stream with no gap
    clr_stats();
    set_req(1, 0, 64, 0); tick();
    set_req(1, 1, 128, 0); tick();
    set_req(0, 0, 0, 0);
    repeat (6) tick();
    chk("b_beats", beats, 3);
    chk("b_span", last_cyc - first_cyc, 2);

    // forward credit blocks host command only
    m_req_ready = 4'b1101;
    set_req(1, 1, 64, 1); settle();
    chk("c_stall", s_req_ready, 0);
    advance();
    chk("c_nopush", seq_used, 0);
    set_req(1, 1, 64, 0); settle();
    chk("c_local_ready", s_req_ready, 1);
    chk("c_local_mreq", m_req_valid, 0);
    advance();
    set_req(0, 0, 0, 0); m_req_ready = '1;
    repeat (5) tick();
    chk("c_drained", cq.size(), 0);

    // fill the queue, then a final beat frees room in the same cycle
    s_axis_tvalid = '0; m_axis_tready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_req(1, i % N_CH, 64, 0); settle();
      chk("d_fill_ready", s_req_ready, 1);
      advance();
    end
    set_req(0, 0, 0, 0); settle();
    chk("d_full_used", seq_used, 16);
    advance();
    set_req(1, 1, 64, 0); settle();
    chk("d_full_stall", s_req_ready, 0);
    advance();
    s_axis_tvalid = '1; m_axis_tready = 1'b1; settle();
    chk("d_pop_ready", s_req_ready, 1);
    advance();
    set_req(0, 0, 0, 0); settle();
    chk("d_used_same", seq_used, 16);
    advance();
    for (int k = 0; k < 200 && cq.size() > 0; k++) tick();
    chk("d_drained", cq.size(), 0);

    // out-of-range ids and a zero-length entry
    set_req(1, 5, 64, 1); settle();
    chk("e_ready", s_req_ready, 1);
    chk("e_mreq", m_req_valid, 0);
    advance();
    set_req(1, 4, 64, 0); settle();
    chk("e_err_pulse", err_vfid, 1);
    chk("e_used", seq_used, 0);
    advance();
    set_req(0, 0, 0, 0); settle();
    chk("e_err_edge", err_vfid, 1);
    advance();
    settle();
    chk("e_err_clear", err_vfid, 0);
    advance();
    clr_stats(); s3 = src_cnt[3];
    set_req(1, 3, 0, 1); tick();
    set_req(1, 0, 64, 0); tick();
    set_req(0, 0, 0, 0);
    repeat (6) tick();
    chk("e_beats", beats, 1);
    chk("e_zero_src", src_cnt[3] - s3, 0);
    chk("e_used_end", seq_used, 0);

    // reset in the middle of a transfer with entries waiting
    clr_stats();
    set_req(1, 3, 256, 0); tick();
    set_req(1, 1, 128, 0); tick();
    set_req(1, 2, 64, 0); tick();
    set_req(0, 0, 0, 0);
    for (int k = 0; k < 20 && beats < 2; k++) tick();
    chk("f_two_beats", beats, 2);
    areset = 1'b1; m_axis_tready = 1'b0;
    tick();
    areset = 1'b0; m_axis_tready = 1'b1;
    cq.delete();
    for (int i = 0; i < N_CH; i++) mdl_cnt[i] = src_cnt[i];
    settle();
    chk("f_tvalid", m_axis_tvalid, 0);
    chk("f_tready", s_axis_tready, 0);
    chk("f_mreq", m_req_valid, 0);
    chk("f_used", seq_used, 0);
    advance();
    repeat (3) tick();
    chk("f_no_more", beats, 2);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      s_axis_tvalid = N_CH'($urandom);
      m_axis_tready = ($urandom_range(0, 3) != 0);
      m_req_ready   = N_CH'($urandom);
      if (cq.size() < 6 && $urandom_range(0, 2) == 0) begin
        v   = $urandom_range(0, 5);
        h   = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 5);
        ln  = (sel == 0) ? 0 : (sel == 1) ? 64 : (sel == 2) ? 128 : $urandom_range(1, 300);
        set_req(1, v, ln, h);
      end else begin
        v = 0; h = 1'b0;
        set_req(0, 0, 0, 0);
      end
      settle();
      exp_mrv = '0;
      if (s_req_valid) begin
        if (v < N_CH && h) exp_mrv[v] = 1'b1;
        chk("r_ready", s_req_ready, (v < N_CH && h) ? m_req_ready[v] : 1'b1);
      end
      chk("r_mreq", m_req_valid, exp_mrv);
      advance();
    end
    set_req(0, 0, 0, 0); s_axis_tvalid = '1; m_axis_tready = 1'b1;
    for (int k = 0; k < 400 && cq.size() > 0; k++) tick();
    chk("r_drained", cq.size(), 0);
    repeat (5) tick();
    settle();
    chk("r_used_end", seq_used, 0);
    chk("r_idle_end", m_axis_tvalid, 0);
    for (int i = 0; i < N_CH; i++) chk("r_src_sync", src_cnt[i], mdl_cnt[i]);
    advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
